// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type, requester count, default geometry and tag-type decode for the memory bus arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_e;
  localparam int NUM_REQ = 2;
  localparam int DEF_NUM_BEATS = 8;
  localparam int DEF_WRITE_TAG_BIT = 12;
  function automatic logic is_write(input logic type_bit);
    return !type_bit;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way pick of the next bus owner
// Ports: req_i request vector, ptr_i round-robin priority pointer (absent when
// MEM_ARB_FIXED_PRIO_EN is defined, requester 1 then always wins ties),
// gnt_o winning index, gnt_valid_o any request present.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic               ptr_i,
`endif
  output logic               gnt_o,
  output logic               gnt_valid_o
);
  assign gnt_valid_o = |req_i;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign gnt_o = req_i[1];
`else
  assign gnt_o = &req_i ? ptr_i : req_i[1];
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Sysbus memory port between the I-cache (0) and D-cache (1)
// Ports: clk, reset (sync, active-low); per-requester c_reqcyc/c_reqack,
// c0/c1_req, c0/c1_reqtag, c_respcyc/c_respack, c0/c1_resp, c0/c1_resptag;
// memory side m_bus_reqcyc/reqack/req/reqtag and m_bus_respcyc/respack/resp/resptag.
// Build option MEM_ARB_FIXED_PRIO_EN: D-cache wins ties, no round-robin pointer.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int NUM_BEATS      = DEF_NUM_BEATS,
  parameter int WRITE_TAG_BIT  = DEF_WRITE_TAG_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        c_reqcyc,
  output logic [NUM_REQ-1:0]        c_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] c0_req,
  input  logic [BUS_DATA_WIDTH-1:0] c1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
  input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
  output logic [NUM_REQ-1:0]        c_respcyc,
  input  logic [NUM_REQ-1:0]        c_respack,
  output logic [BUS_DATA_WIDTH-1:0] c0_resp,
  output logic [BUS_DATA_WIDTH-1:0] c1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,
  output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,
  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
);
  localparam int CW = $clog2(NUM_BEATS) + 1;
  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt, gnt_valid, fwd_req, fwd_rsp, hs_req, hs_rsp, last;
  assign fwd_req = (state_q == ADDR) || (state_q == WDATA);
  assign fwd_rsp = state_q == RDATA;
  assign m_bus_reqcyc  = fwd_req & c_reqcyc[owner_q];
  assign m_bus_req     = fwd_req ? (owner_q ? c1_req : c0_req) : '0;
  assign m_bus_reqtag  = fwd_req ? (owner_q ? c1_reqtag : c0_reqtag) : '0;
  assign c_reqack      = fwd_req ? {owner_q & m_bus_reqack, ~owner_q & m_bus_reqack} : '0;
  assign m_bus_respack = fwd_rsp & c_respack[owner_q];
  assign c_respcyc     = fwd_rsp ? {owner_q & m_bus_respcyc, ~owner_q & m_bus_respcyc} : '0;
  assign c0_resp       = (fwd_rsp & ~owner_q) ? m_bus_resp : '0;
  assign c1_resp       = (fwd_rsp & owner_q) ? m_bus_resp : '0;
  assign c0_resptag    = (fwd_rsp & ~owner_q) ? m_bus_resptag : '0;
  assign c1_resptag    = (fwd_rsp & owner_q) ? m_bus_resptag : '0;
  assign hs_req = m_bus_reqcyc & m_bus_reqack;
  assign hs_rsp = m_bus_respcyc & m_bus_respack;
  assign last   = cnt_q == CW'(NUM_BEATS - 1);
`ifdef MEM_ARB_FIXED_PRIO_EN
  rr_arbiter2 u_pick (.req_i(c_reqcyc), .gnt_o(gnt), .gnt_valid_o(gnt_valid));
`else
  logic rr_q;
  rr_arbiter2 u_pick (.req_i(c_reqcyc), .ptr_i(rr_q), .gnt_o(gnt), .gnt_valid_o(gnt_valid));
  always_ff @(posedge clk)
    if (!reset) rr_q <= 1'b0;
    else if (state_d == IDLE && state_q != IDLE) rr_q <= ~owner_q;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (gnt_valid) begin
        owner_d = gnt;
        state_d = ADDR;
      end
      ADDR: if (hs_req) begin
        cnt_d   = '0;
        state_d = is_write(m_bus_reqtag[WRITE_TAG_BIT]) ? WDATA : RDATA;
      end
      default: if (hs_req || hs_rsp) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? IDLE : state_q;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single DRAM-side Sysbus port between two cache controllers (requester 0 = instruction cache, requester 1 = data cache).
- Each requester drives its m_bus_* side exactly as a lone cache would; the arbiter grants one owner per transaction, passes its handshakes through, and routes memory responses back to it.
- Ownership is held for the whole transaction: request beat plus 8 write-data beats, or request beat plus 8 read-response beats.

Parameters:
- BUS_DATA_WIDTH, 64, width of request/response data buses.
- BUS_TAG_WIDTH, 13, width of request/response tags.
- NUM_BEATS, 8, data beats per transaction (one 512-bit line).
- WRITE_TAG_BIT, 12, tag bit that selects the transaction type: 0 = write, 1 = read.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset: the block resets on a rising clk edge while reset==0.
- c_reqcyc  in  2  per-requester request valid.
- c_reqack  out  2  per-requester request acknowledge.
- c0_req, c1_req  in  BUS_DATA_WIDTH  request address or write data.
- c0_reqtag, c1_reqtag  in  BUS_TAG_WIDTH  request tags.
- c_respcyc  out  2  per-requester response valid.
- c_respack  in  2  per-requester response acknowledge.
- c0_resp, c1_resp  out  BUS_DATA_WIDTH  response data.
- c0_resptag, c1_resptag  out  BUS_TAG_WIDTH  response tags.
- m_bus_reqcyc  out  1  memory-side request valid.
- m_bus_reqack  in  1  memory-side request acknowledge.
- m_bus_req  out  BUS_DATA_WIDTH  memory-side request address/data.
- m_bus_reqtag  out  BUS_TAG_WIDTH  memory-side request tag.
- m_bus_respcyc  in  1  memory-side response valid.
- m_bus_respack  out  1  memory-side response acknowledge.
- m_bus_resp  in  BUS_DATA_WIDTH  memory-side response data.
- m_bus_resptag  in  BUS_TAG_WIDTH  memory-side response tag.

Behaviour:
- Reset: all cyc/ack outputs 0; all data/tag outputs 0; state IDLE; owner 0; rr_ptr 0; beat_cnt 0. Reset has priority over every other event, and asserting it mid-transaction abandons the transaction with no cleanup beats.
- Registered state: state, owner (1 bit), rr_ptr (1 bit, the requester that gets priority next), beat_cnt (clog2(NUM_BEATS)+1 bits).
- All outputs are combinational from the registered state plus the current inputs.
- IDLE:
  - No forwarding; m_bus_reqcyc=0 and m_bus_respack=0 (any early memory response stalls).
  - If any c_reqcyc bit is set: owner <= winner, go to ADDR. Grant latency is 1 cycle.
  - Winner when both request: the requester at rr_ptr. Winner when one requests: that requester.
- ADDR:
  - m_bus_reqcyc/req/reqtag mirror the owner's inputs; c_reqack[owner]=m_bus_reqack; non-owner reqack=0.
  - On m_bus_reqcyc&&m_bus_reqack: latch the tag type, clear beat_cnt.
  - Next state is WDATA if reqtag[WRITE_TAG_BIT]==0, otherwise RDATA.
  - m_bus_respack is 0 in this state.
- WDATA:
  - Same request pass-through as ADDR.
  - Each req handshake increments beat_cnt.
  - On the NUM_BEATS-th handshake: go to IDLE, rr_ptr <= ~owner.
- RDATA:
  - m_bus_reqcyc=0.
  - c_respcyc[owner]=m_bus_respcyc; m_bus_respack=c_respack[owner].
  - Owner resp/resptag = m_bus_resp/resptag; non-owner respcyc=0, resp/resptag=0.
  - Each resp handshake (respcyc&&respack) increments beat_cnt.
  - On the NUM_BEATS-th handshake: go to IDLE, rr_ptr <= ~owner.
- The owner dropping reqcyc mid-transaction does not abort: the arbiter waits indefinitely.
- Non-owner requests are never acked, and the non-owner waits without loss.
- Back-to-back transactions: completion cycle -> IDLE -> grant. This gives a minimum 1 idle cycle between transactions.
- resptag is not checked; responses in RDATA always belong to the owner.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: requester 1 (D-cache) always wins simultaneous requests; rr_ptr is not implemented.
- Undefined: round-robin as described under Behaviour.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, ADDR, WDATA, RDATA};
  - NUM_REQ=2;
  - the NUM_BEATS and WRITE_TAG_BIT defaults;
  - a helper function is_write(tag).
- One sub-module rr_arbiter2: combinational 2-way pick from the req vector and priority pointer, outputting grant index and grant_valid. The fixed-priority macro lives here.

Test Plan:
- Single read from c0 (tag[12]=1, addr 0x1000) -> granted next cycle; m_bus_req=0x1000; 8 response beats 0..7 appear on c0_resp only; c1_respcyc stays 0; return to IDLE.
- Single write from c1 (tag[12]=0) with data 0xA0..0xA7 -> m_bus_req shows addr then 0xA0..0xA7 in order; c1_reqack pulses 9 times; exactly 8 data beats forwarded.
- c0 and c1 request in the same cycle, repeated 4 transactions -> grants alternate 0,1,0,1. With MEM_ARB_FIXED_PRIO_EN: grants are 1,1,1,1 while c1 keeps requesting.
- Memory delays reqack 5 cycles and respack backpressure is applied for 3 cycles on beat 4 -> no beat dropped or duplicated; beat_cnt reaches exactly 8.
- reset=0 asserted during RDATA beat 3 -> next cycle all outputs 0, state IDLE; a fresh c1 read then completes normally.
- m_bus_respcyc=1 while IDLE -> m_bus_respack stays 0 and no c_respcyc asserted.
